// File: rtl/core_pkg.sv
// Shared decode definitions: uop width, the filler uop, opcode values,
// per-opcode uop encodings and the operand-length / assembly-state enums.
package core_pkg;

  localparam int UOP_WIDTH = 20;

  // Filler uop driven on every unused slot.
  localparam logic [UOP_WIDTH-1:0] UOP_NOP = 20'b0000_0000_1111_00_000_000;

  localparam logic [7:0] OP_NOP     = 8'hEA;
  localparam logic [7:0] OP_LDA_IMM = 8'hA9;
  localparam logic [7:0] OP_STA_ABS = 8'h8D;
  localparam logic [7:0] OP_ADC_ZP  = 8'h65;

  // Micro-op encodings produced by the ROM.
  localparam logic [UOP_WIDTH-1:0] UOP_LDA_0 = 20'h10A01;
  localparam logic [UOP_WIDTH-1:0] UOP_STA_0 = 20'h20B01;
  localparam logic [UOP_WIDTH-1:0] UOP_STA_1 = 20'h20B12;
  localparam logic [UOP_WIDTH-1:0] UOP_STA_2 = 20'h20B23;
  localparam logic [UOP_WIDTH-1:0] UOP_ADC_0 = 20'h30C01;
  localparam logic [UOP_WIDTH-1:0] UOP_ADC_1 = 20'h30C12;

  typedef enum logic [1:0] {
    LEN_0 = 2'd0,
    LEN_1 = 2'd1,
    LEN_2 = 2'd2
  } op_len_e;

  typedef enum logic [1:0] {
    ST_OPC = 2'd0,
    ST_LO  = 2'd1,
    ST_HI  = 2'd2
  } asm_state_e;

endpackage

// File: rtl/uop_rom.sv
// Combinational micro-op ROM: opcode -> up to three uops, uop count,
// operand length and an illegal flag. Unmapped opcodes decode to a
// single NOP uop with no operand.
module uop_rom
  import core_pkg::*;
(
  input  logic [7:0]           opcode,
  output logic [UOP_WIDTH-1:0] uop0,
  output logic [UOP_WIDTH-1:0] uop1,
  output logic [UOP_WIDTH-1:0] uop2,
  output logic [1:0]           count,
  output op_len_e              len,
  output logic                 illegal
);

  // Opcode lookup; defaults describe the illegal-opcode expansion.
  always_comb begin
    uop0    = UOP_NOP;
    uop1    = UOP_NOP;
    uop2    = UOP_NOP;
    count   = 2'd1;
    len     = LEN_0;
    illegal = 1'b0;
    case (opcode)
      OP_NOP: begin
        uop0  = UOP_NOP;
        count = 2'd1;
        len   = LEN_0;
      end
      OP_LDA_IMM: begin
        uop0  = UOP_LDA_0;
        count = 2'd1;
        len   = LEN_2;
      end
      OP_STA_ABS: begin
        uop0  = UOP_STA_0;
        uop1  = UOP_STA_1;
        uop2  = UOP_STA_2;
        count = 2'd3;
        len   = LEN_2;
      end
      OP_ADC_ZP: begin
        uop0  = UOP_ADC_0;
        uop1  = UOP_ADC_1;
        count = 2'd2;
        len   = LEN_1;
      end
      default: begin
        uop0    = UOP_NOP;
        count   = 2'd1;
        len     = LEN_0;
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/id_uop_feeder.sv
// Decode-side feeder: assembles opcode + operand bytes from fetch into a
// decoded instruction (uops, count, 16-bit operand), parks it in a single
// hold register and hands it to the reservation station on request.
module id_uop_feeder
  import core_pkg::*;
#(
  parameter int               UOP_W = UOP_WIDTH,
  parameter logic [UOP_W-1:0] NOP   = UOP_NOP
)(
  input  logic             clk,
  input  logic             a_rst,
  input  logic [7:0]       if_byte,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic             id_flush,
  input  logic             id_feed_req,
  output logic [UOP_W-1:0] id_uop_0,
  output logic [UOP_W-1:0] id_uop_1,
  output logic [UOP_W-1:0] id_uop_2,
  output logic [1:0]       id_uop_count,
  output logic [15:0]      id_k16,
  output logic             id_illegal
);

  asm_state_e       state_r;
  logic [UOP_W-1:0] pend_uop0_r, pend_uop1_r, pend_uop2_r;
  logic [1:0]       pend_count_r;
  op_len_e          pend_len_r;
  logic [7:0]       lo_byte_r;

  logic [UOP_W-1:0] hold_uop0_r, hold_uop1_r, hold_uop2_r;
  logic [1:0]       hold_count_r;
  logic [15:0]      hold_k16_r;
  logic             illegal_r;

  logic [UOP_W-1:0] rom_uop0_s, rom_uop1_s, rom_uop2_s;
  logic [1:0]       rom_count_s;
  op_len_e          rom_len_s;
  logic             rom_illegal_s;

  logic             hold_full_s;
  logic             transfer_s;
  logic             if_ready_s;
  logic             accept_s;
  logic             complete_s;
  logic [UOP_W-1:0] new_uop0_s, new_uop1_s, new_uop2_s;
  logic [1:0]       new_count_s;
  logic [15:0]      new_k16_s;

  uop_rom u_rom (
    .opcode  (if_byte),
    .uop0    (rom_uop0_s),
    .uop1    (rom_uop1_s),
    .uop2    (rom_uop2_s),
    .count   (rom_count_s),
    .len     (rom_len_s),
    .illegal (rom_illegal_s)
  );

  // Handshake: a full hold register only frees up when the station takes it.
  always_comb begin
    hold_full_s = (hold_count_r != 2'd0);
    transfer_s  = id_feed_req & hold_full_s;
    if_ready_s  = ~id_flush & (~hold_full_s | transfer_s);
    accept_s    = if_valid & if_ready_s;
  end

  // Next instruction image and whether the accepted byte completes it.
  always_comb begin
    new_uop0_s  = rom_uop0_s;
    new_uop1_s  = rom_uop1_s;
    new_uop2_s  = rom_uop2_s;
    new_count_s = rom_count_s;
    new_k16_s   = 16'h0000;
    complete_s  = 1'b0;
    case (state_r)
      ST_OPC: begin
        complete_s = accept_s & (rom_len_s == LEN_0);
      end
      ST_LO: begin
        new_uop0_s  = pend_uop0_r;
        new_uop1_s  = pend_uop1_r;
        new_uop2_s  = pend_uop2_r;
        new_count_s = pend_count_r;
        new_k16_s   = {8'h00, if_byte};
        complete_s  = accept_s & (pend_len_r == LEN_1);
      end
      ST_HI: begin
        new_uop0_s  = pend_uop0_r;
        new_uop1_s  = pend_uop1_r;
        new_uop2_s  = pend_uop2_r;
        new_count_s = pend_count_r;
        new_k16_s   = {if_byte, lo_byte_r};
        complete_s  = accept_s;
      end
      default: begin
        complete_s = 1'b0;
      end
    endcase
  end

  // Assembly FSM, pending-opcode latch, hold register and illegal pulse.
  always_ff @(posedge clk or negedge a_rst) begin
    if (!a_rst) begin
      state_r      <= ST_OPC;
      pend_uop0_r  <= NOP;
      pend_uop1_r  <= NOP;
      pend_uop2_r  <= NOP;
      pend_count_r <= 2'd0;
      pend_len_r   <= LEN_0;
      lo_byte_r    <= 8'h00;
      hold_uop0_r  <= NOP;
      hold_uop1_r  <= NOP;
      hold_uop2_r  <= NOP;
      hold_count_r <= 2'd0;
      hold_k16_r   <= 16'h0000;
      illegal_r    <= 1'b0;
    end else if (id_flush) begin
      state_r      <= ST_OPC;
      hold_uop0_r  <= NOP;
      hold_uop1_r  <= NOP;
      hold_uop2_r  <= NOP;
      hold_count_r <= 2'd0;
      hold_k16_r   <= 16'h0000;
      illegal_r    <= 1'b0;
    end else begin
      illegal_r <= accept_s & (state_r == ST_OPC) & rom_illegal_s;

      if (complete_s) begin
        hold_uop0_r  <= new_uop0_s;
        hold_uop1_r  <= (new_count_s >= 2'd2) ? new_uop1_s : NOP;
        hold_uop2_r  <= (new_count_s == 2'd3) ? new_uop2_s : NOP;
        hold_count_r <= new_count_s;
        hold_k16_r   <= new_k16_s;
      end else if (transfer_s) begin
        hold_uop0_r  <= NOP;
        hold_uop1_r  <= NOP;
        hold_uop2_r  <= NOP;
        hold_count_r <= 2'd0;
        hold_k16_r   <= 16'h0000;
      end

      if (accept_s) begin
        case (state_r)
          ST_OPC: begin
            if (rom_len_s != LEN_0) begin
              state_r      <= ST_LO;
              pend_uop0_r  <= rom_uop0_s;
              pend_uop1_r  <= rom_uop1_s;
              pend_uop2_r  <= rom_uop2_s;
              pend_count_r <= rom_count_s;
              pend_len_r   <= rom_len_s;
            end
          end
          ST_LO: begin
            lo_byte_r <= if_byte;
            state_r   <= (pend_len_r == LEN_1) ? ST_OPC : ST_HI;
          end
          ST_HI: begin
            state_r <= ST_OPC;
          end
          default: begin
            state_r <= ST_OPC;
          end
        endcase
      end
    end
  end

  assign if_ready     = if_ready_s;
  assign id_uop_0     = hold_uop0_r;
  assign id_uop_1     = hold_uop1_r;
  assign id_uop_2     = hold_uop2_r;
  assign id_uop_count = hold_count_r;
  assign id_k16       = hold_k16_r;
  assign id_illegal   = illegal_r;

endmodule

// File: tb/tb_id_uop_feeder.sv
// Directed self-checking bench for id_uop_feeder.
module tb_id_uop_feeder;

  localparam logic [19:0] E_NOP   = 20'h00F00;
  localparam logic [19:0] E_LDA   = 20'h10A01;
  localparam logic [19:0] E_STA_0 = 20'h20B01;
  localparam logic [19:0] E_STA_1 = 20'h20B12;
  localparam logic [19:0] E_STA_2 = 20'h20B23;
  localparam logic [19:0] E_ADC_0 = 20'h30C01;
  localparam logic [19:0] E_ADC_1 = 20'h30C12;

  logic        clk = 1'b0;
  logic        a_rst;
  logic [7:0]  if_byte;
  logic        if_valid;
  logic        if_ready;
  logic        id_flush;
  logic        id_feed_req;
  logic [19:0] id_uop_0, id_uop_1, id_uop_2;
  logic [1:0]  id_uop_count;
  logic [15:0] id_k16;
  logic        id_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  id_uop_feeder dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .if_byte      (if_byte),
    .if_valid     (if_valid),
    .if_ready     (if_ready),
    .id_flush     (id_flush),
    .id_feed_req  (id_feed_req),
    .id_uop_0     (id_uop_0),
    .id_uop_1     (id_uop_1),
    .id_uop_2     (id_uop_2),
    .id_uop_count (id_uop_count),
    .id_k16       (id_k16),
    .id_illegal   (id_illegal)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_port(input string tag, input logic [1:0] cnt, input logic [19:0] u0,
                            input logic [19:0] u1, input logic [19:0] u2, input logic [15:0] k);
    check_eq({tag, ".cnt"}, 32'(id_uop_count), 32'(cnt));
    check_eq({tag, ".u0"},  32'(id_uop_0), 32'(u0));
    check_eq({tag, ".u1"},  32'(id_uop_1), 32'(u1));
    check_eq({tag, ".u2"},  32'(id_uop_2), 32'(u2));
    check_eq({tag, ".k16"}, 32'(id_k16), 32'(k));
  endtask

  // Advance one clock; inputs/outputs settle 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] b);
    if_valid = 1'b1;
    if_byte  = b;
    step();
    if_valid = 1'b0;
  endtask

  initial begin
    a_rst       = 1'b0;
    if_byte     = 8'h00;
    if_valid    = 1'b0;
    id_flush    = 1'b0;
    id_feed_req = 1'b0;
    #12;
    check_port("rst", 2'd0, E_NOP, E_NOP, E_NOP, 16'h0000);
    check_eq("rst.illegal", 32'(id_illegal), 32'd0);
    check_eq("rst.ready", 32'(if_ready), 32'd1);
    @(posedge clk);
    #1 a_rst = 1'b1;

    // Length-0 opcode with request held high
    id_feed_req = 1'b1;
    feed(8'hEA);
    check_port("nop1", 2'd1, E_NOP, E_NOP, E_NOP, 16'h0000);
    step();
    check_eq("nop1.drain", 32'(id_uop_count), 32'd0);

    // LDA #imm held without request, then backpressure
    id_feed_req = 1'b0;
    feed(8'hA9);
    check_eq("lda.partial", 32'(id_uop_count), 32'd0);
    feed(8'h34);
    feed(8'h12);
    check_port("lda", 2'd1, E_LDA, E_NOP, E_NOP, 16'h1234);
    step(); step(); step();
    check_port("lda.hold", 2'd1, E_LDA, E_NOP, E_NOP, 16'h1234);
    if_valid = 1'b1;
    if_byte  = 8'hEA;
    #1 check_eq("bp.ready_low", 32'(if_ready), 32'd0);
    step();
    check_port("bp.blocked", 2'd1, E_LDA, E_NOP, E_NOP, 16'h1234);
    id_feed_req = 1'b1;
    #1 check_eq("bp.ready_xfer", 32'(if_ready), 32'd1);
    step();
    if_valid = 1'b0;
    check_port("bp.refill", 2'd1, E_NOP, E_NOP, E_NOP, 16'h0000);
    step();
    check_eq("bp.drain", 32'(id_uop_count), 32'd0);

    // Stream of length-0 opcodes, one transfer per cycle
    for (int i = 0; i < 8; i++) begin
      if_valid = 1'b1;
      if_byte  = 8'hEA;
      #1 check_eq($sformatf("stream%0d.ready", i), 32'(if_ready), 32'd1);
      step();
      check_eq($sformatf("stream%0d.cnt", i), 32'(id_uop_count), 32'd1);
    end
    if_valid = 1'b0;
    step();
    check_eq("stream.drain", 32'(id_uop_count), 32'd0);

    // ADC zp: one operand byte
    id_feed_req = 1'b0;
    feed(8'h65);
    feed(8'h80);
    check_port("adc", 2'd2, E_ADC_0, E_ADC_1, E_NOP, 16'h0080);
    id_feed_req = 1'b1;
    step();
    check_eq("adc.drain", 32'(id_uop_count), 32'd0);

    // STA abs: three uops
    id_feed_req = 1'b0;
    feed(8'h8D);
    feed(8'h00);
    feed(8'h20);
    check_port("sta", 2'd3, E_STA_0, E_STA_1, E_STA_2, 16'h2000);
    id_feed_req = 1'b1;
    step();
    check_eq("sta.drain", 32'(id_uop_count), 32'd0);

    // Flush before the high operand byte
    id_feed_req = 1'b0;
    feed(8'h8D);
    feed(8'h00);
    if_valid = 1'b1;
    if_byte  = 8'h12;
    id_flush = 1'b1;
    #1 check_eq("flush.ready", 32'(if_ready), 32'd0);
    step();
    id_flush = 1'b0;
    if_valid = 1'b0;
    check_eq("flush.cnt", 32'(id_uop_count), 32'd0);
    step();
    check_eq("flush.cnt2", 32'(id_uop_count), 32'd0);
    feed(8'hEA);
    check_port("flush.next", 2'd1, E_NOP, E_NOP, E_NOP, 16'h0000);
    id_feed_req = 1'b1;
    step();
    check_eq("flush.drain", 32'(id_uop_count), 32'd0);

    // Unmapped opcode
    id_feed_req = 1'b0;
    feed(8'h02);
    check_eq("ill.pulse", 32'(id_illegal), 32'd1);
    check_port("ill", 2'd1, E_NOP, E_NOP, E_NOP, 16'h0000);
    id_feed_req = 1'b1;
    step();
    check_eq("ill.pulse_end", 32'(id_illegal), 32'd0);
    check_eq("ill.drain", 32'(id_uop_count), 32'd0);

    // Asynchronous reset while waiting for the high operand byte
    id_feed_req = 1'b0;
    feed(8'hA9);
    feed(8'h34);
    #2 a_rst = 1'b0;
    #1;
    check_port("arst", 2'd0, E_NOP, E_NOP, E_NOP, 16'h0000);
    check_eq("arst.ready", 32'(if_ready), 32'd1);
    check_eq("arst.illegal", 32'(id_illegal), 32'd0);
    @(posedge clk);
    #1 a_rst = 1'b1;
    feed(8'h65);
    feed(8'h07);
    check_port("arst.resume", 2'd2, E_ADC_0, E_ADC_1, E_NOP, 16'h0007);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
